// File: rtl/cnn_input_framer.sv
// cnn_input_framer: gates raw ADC samples into fixed-length windows of offset-removed,
// saturated fixed-point samples for the CNN input, with a one-deep output register.
module cnn_input_framer #(
  parameter int ADC_WIDTH   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int FRACTION    = 24,
  parameter int WINDOW_SIZE = 254,
  parameter int OFFSET      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  adc_valid,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  output logic                  adc_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  window_done,
  output logic [15:0]           drop_count
);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2;
  localparam int SH = FRACTION - (ADC_WIDTH - 1);
  localparam int CW = $clog2(WINDOW_SIZE);
  localparam logic signed [ADC_WIDTH:0] OFF = (ADC_WIDTH + 1)'(OFFSET);
  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW_SIZE - 1);

  if (ADC_WIDTH - 1 > FRACTION || FRACTION >= DATA_WIDTH || WINDOW_SIZE < 2) begin : g_bad_params
    $error("cnn_input_framer: illegal parameter combination");
  end

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           drop_q, drop_d;
  logic                  ov_q, ov_d, ol_q, ol_d;
  logic [DATA_WIDTH-1:0] od_q, od_d, conv;
  logic signed [ADC_WIDTH:0]   diff;
  logic signed [ADC_WIDTH-1:0] sat;
  logic accept, is_last;

  // one guard bit catches overflow of the offset subtraction
  assign diff = $signed({adc_data[ADC_WIDTH-1], adc_data}) - OFF;
  assign sat  = (diff[ADC_WIDTH] ^ diff[ADC_WIDTH-1]) ? {diff[ADC_WIDTH], {(ADC_WIDTH-1){~diff[ADC_WIDTH]}}}
                                                      : diff[ADC_WIDTH-1:0];
  assign conv = DATA_WIDTH'(sat) << SH;

  assign adc_ready   = rst ? 1'b0 : state_q == IDLE ? 1'b1 : state_q == STREAM ? (!ov_q || out_ready) : 1'b0;
  assign accept      = state_q == STREAM && adc_valid && adc_ready;
  assign is_last     = cnt_q == LAST_IDX;
  assign window_done = !rst && state_q == FLUSH && ov_q && out_ready && ol_q;
  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign out_last    = ol_q;
  assign busy        = state_q != IDLE;
  assign drop_count  = drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    od_d    = od_q;
    if (state_q == IDLE) begin
      if (adc_valid && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      if (start) begin
        state_d = STREAM;
        cnt_d   = '0;
      end
    end
    if (accept) begin
      ov_d  = 1'b1;
      od_d  = conv;
      ol_d  = is_last;
      cnt_d = cnt_q + 1'b1;
      if (is_last) state_d = FLUSH;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end
    if (window_done) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      od_q    <= od_d;
    end
  end
endmodule

// File: tb/tb_cnn_input_framer.sv
// tb_cnn_input_framer: directed checks of framing, conversion, backpressure, drops and reset.
module tb_cnn_input_framer;
  logic clk = 0, rst = 1, start = 0, adc_valid = 0, out_ready = 0;
  logic [15:0] adc_data = 0;
  logic rdy0, ov0, ol0, busy0, wd0, rdy1, ov1, ol1, busy1, wd1;
  logic [31:0] od0, od1;
  logic [15:0] dc0, dc1;
  int n_checks = 0, n_err = 0, n_hs = 0, n_wd = 0, hs_snap, wd_snap;

  always #5 clk = ~clk;

  cnn_input_framer #(.WINDOW_SIZE(4), .OFFSET(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_ready(out_ready),
    .busy(busy0), .window_done(wd0), .drop_count(dc0));

  cnn_input_framer #(.WINDOW_SIZE(4), .OFFSET(100)) u1 (
    .clk(clk), .rst(rst), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_ready(out_ready),
    .busy(busy1), .window_done(wd1), .drop_count(dc1));

  always @(posedge clk) begin
    if (ov0 && out_ready) n_hs++;
    if (wd0) n_wd++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s;
    rst = 1; adc_valid = 1; adc_data = 16'h1111;
    tick();
    chk("rst_adc_ready", rdy0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_drop", dc0, 0);
    chk("rst_wd", wd0, 0);
    rst = 0; out_ready = 1;
    #1 chk("idle_ready", rdy0, 1);
    tick();
    tick();
    start = 1;
    tick();
    start = 0; adc_valid = 0;
    #1 chk("drop_count3", dc0, 3);
    chk("busy_stream", busy0, 1);
    chk("no_out_yet", ov0, 0);
    hs_snap = n_hs;
    adc_valid = 1; adc_data = 16'h4000;
    tick();
    chk("half_u0", od0, 32'h0080_0000);
    chk("half_u1", od1, 32'h007F_3800);
    chk("half_valid", ov0, 1);
    chk("half_last", ol0, 0);
    adc_data = 16'h8000;
    tick();
    chk("neg_u0", od0, 32'hFF00_0000);
    chk("neg_sat_u1", od1, 32'hFF00_0000);
    adc_data = 16'h7FFF;
    tick();
    chk("pos_u0", od0, 32'h00FF_FE00);
    chk("pos_u1", od1, 32'h00FF_3600);
    chk("pos_last", ol0, 0);
    adc_data = 16'h0001; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_ready", rdy0, 0);
      tick();
      chk("stall_data", od0, 32'h00FF_FE00);
      chk("stall_valid", ov0, 1);
    end
    chk("stall_drop", dc0, 3);
    out_ready = 1;
    #1 chk("unstall_ready", rdy0, 1);
    tick();
    chk("last_data", od0, 32'h0000_0200);
    chk("last_flag", ol0, 1);
    chk("flush_ready", rdy0, 0);
    chk("flush_busy", busy0, 1);
    chk("wd_pulse", wd0, 1);
    tick();
    chk("win1_outputs", n_hs - hs_snap, 4);
    chk("win1_wd_count", n_wd, 1);
    chk("idle_busy", busy0, 0);
    chk("idle_valid", ov0, 0);
    chk("idle_wd_low", wd0, 0);
    chk("flush_no_drop", dc0, 3);
    adc_valid = 0; start = 1;
    tick();
    start = 0;
    chk("b2b_stream", busy0, 1);
    adc_valid = 1; adc_data = 16'h0100;
    tick();
    adc_data = 16'h0200;
    tick();
    chk("abort_data", od0, 32'h0004_0000);
    rst = 1;
    tick();
    rst = 0; adc_valid = 0;
    chk("abort_busy", busy0, 0);
    chk("abort_valid", ov0, 0);
    chk("abort_data_clr", od0, 0);
    chk("abort_drop_clr", dc0, 0);
    wd_snap = n_wd;
    start = 1;
    tick();
    start = 0;
    hs_snap = n_hs;
    adc_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      s = 16'(i * 16);
      adc_data = s;
      tick();
      chk("win2_data", od0, 32'(i * 16 * 512));
      chk("win2_last", ol0, i == 4);
    end
    adc_valid = 0;
    tick();
    chk("win2_outputs", n_hs - hs_snap, 4);
    chk("win2_wd", n_wd - wd_snap, 1);
    chk("abort_no_wd", wd_snap, 1);
    chk("win2_idle", busy0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
